// File: rtl/lsu_clkgate_pmctl.sv
// LSU clock-gate sleep/wake controller: idle hysteresis, PMU req/ack handshake, wake stall.
// Optional gated-cycle statistics counter enabled by defining RV_LSU_CLKGATE_STATS_EN.
module lsu_clkgate_pmctl #(
  parameter int unsigned IDLE_CNT_W   = 4,
  parameter int unsigned SLEEP_THRESH = 8
) (
  input  logic                  free_clk,
  input  logic                  rst,
  input  logic                  lsu_pipe_busy,
  input  logic                  lsu_bus_buffer_empty_any,
  input  logic                  lsu_stbuf_empty_any,
  input  logic                  dma_dccm_req,
  input  logic                  clk_override,
  input  logic                  pmu_sleep_ack,
  output logic                  pmu_sleep_req,
  output logic                  lsu_clk_gate_en,
  output logic                  lsu_wake_stall,
  output logic [IDLE_CNT_W-1:0] lsu_idle_cnt
`ifdef RV_LSU_CLKGATE_STATS_EN
  ,
  output logic [31:0]           lsu_gated_cycles
`endif
);

  typedef enum logic [2:0] {
    ACTIVE    = 3'd0,
    IDLE_WAIT = 3'd1,
    REQ       = 3'd2,
    SLEEP     = 3'd3,
    WAKE      = 3'd4
  } state_t;

  localparam logic [IDLE_CNT_W-1:0] THRESH = IDLE_CNT_W'(SLEEP_THRESH);

  state_t state;
  logic   idle;

  assign idle = ~lsu_pipe_busy & lsu_bus_buffer_empty_any & lsu_stbuf_empty_any &
                ~dma_dccm_req & ~clk_override;

  // req/gate_en are updated on the same edge as the state they decode, so they stay glitch-free.
  always_ff @(posedge free_clk or posedge rst) begin
    if (rst) begin
      state           <= ACTIVE;
      lsu_idle_cnt    <= '0;
      pmu_sleep_req   <= 1'b0;
      lsu_clk_gate_en <= 1'b0;
    end else begin
      case (state)
        ACTIVE: begin
          if (idle) begin
            state        <= IDLE_WAIT;
            lsu_idle_cnt <= IDLE_CNT_W'(1);
          end else begin
            lsu_idle_cnt <= '0;
          end
        end
        IDLE_WAIT: begin
          if (!idle) begin
            state        <= ACTIVE;
            lsu_idle_cnt <= '0;
          end else if (lsu_idle_cnt == THRESH) begin
            state         <= REQ;
            pmu_sleep_req <= 1'b1;
          end else if (lsu_idle_cnt != '1) begin
            lsu_idle_cnt <= lsu_idle_cnt + IDLE_CNT_W'(1);
          end
        end
        REQ: begin
          // Activity wins over a same-cycle ack.
          if (!idle) begin
            state         <= ACTIVE;
            lsu_idle_cnt  <= '0;
            pmu_sleep_req <= 1'b0;
          end else if (pmu_sleep_ack) begin
            state           <= SLEEP;
            lsu_clk_gate_en <= 1'b1;
          end
        end
        SLEEP: begin
          if (!idle) begin
            state           <= WAKE;
            pmu_sleep_req   <= 1'b0;
            lsu_clk_gate_en <= 1'b0;
          end
        end
        WAKE: begin
          if (!pmu_sleep_ack) begin
            state        <= ACTIVE;
            lsu_idle_cnt <= '0;
          end
        end
        default: begin
          state           <= ACTIVE;
          lsu_idle_cnt    <= '0;
          pmu_sleep_req   <= 1'b0;
          lsu_clk_gate_en <= 1'b0;
        end
      endcase
    end
  end

  assign lsu_wake_stall = ((state == SLEEP) & ~idle) | (state == WAKE);

`ifdef RV_LSU_CLKGATE_STATS_EN
  logic [31:0] gated_cnt;

  always_ff @(posedge free_clk or posedge rst) begin
    if (rst) begin
      gated_cnt <= '0;
    end else if ((state == SLEEP) && (gated_cnt != '1)) begin
      gated_cnt <= gated_cnt + 32'd1;
    end
  end

  assign lsu_gated_cycles = gated_cnt;
`endif

endmodule
